mem_access_initiator: RTL and testbench

Initiator side of the data-RAM port: takes one load/store request at a time from the MEM stage, drives `ram_en`/`ram_write_en`/`ram_addr`/`ram_write_data` for exactly one cycle, and returns an aligned, sign- or zero-extended load result. It performs byte-lane steering and alignment checking. It also provides a registered valid/ready handshake toward the pipeline. It sits between the CPU MEM stage and the single-cycle-read, posedge-write data RAM.

---
 rtl/mem_access_initiator_pkg.sv | 27 ++
 rtl/mem_access_initiator_align.sv | 61 ++++++
 rtl/mem_access_initiator.sv | 135 +++++++++++++
 tb/tb_mem_access_initiator.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_initiator_pkg.sv
// Shared bus widths and access-size codes for the data-RAM initiator.
// Also holds the alignment rule used by the lane-steering logic.
package mem_access_initiator_pkg;

    localparam int ADDR_BUS     = 32;
    localparam int DATA_BUS     = 32;
    localparam int MEM_SEL_BUS  = DATA_BUS / 8;
    localparam int MEM_SIZE_BUS = 2;

    localparam logic [MEM_SIZE_BUS-1:0] MEM_SIZE_B = 2'd0;
    localparam logic [MEM_SIZE_BUS-1:0] MEM_SIZE_H = 2'd1;
    localparam logic [MEM_SIZE_BUS-1:0] MEM_SIZE_W = 2'd2;

    // Size code 3 behaves as a word access everywhere.
    function automatic logic is_misaligned(input logic [MEM_SIZE_BUS-1:0] size,
                                           input logic [1:0]              offset);
        logic mis;
        mis = 1'b0;
        case (size)
            MEM_SIZE_B: mis = 1'b0;
            MEM_SIZE_H: mis = offset[0];
            default:    mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_initiator_align.sv
// Combinational byte-lane steering: alignment check, store strobes and
// lane-replicated data, and load extract with sign/zero extension.
module mem_lane_align
    import mem_access_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS
) (
    input  logic [MEM_SIZE_BUS-1:0]  chk_size,
    input  logic [1:0]               chk_offset,
    output logic                     misaligned,
    input  logic [MEM_SIZE_BUS-1:0]  size,
    input  logic                     sign_ext,
    input  logic [1:0]               offset,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [DATA_WIDTH-1:0]    rdata,
    output logic [DATA_WIDTH/8-1:0]  strobe,
    output logic [DATA_WIDTH-1:0]    wdata_rep,
    output logic [DATA_WIDTH-1:0]    rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign misaligned = is_misaligned(chk_size, chk_offset);

    always_comb begin
        rd_byte = 8'h00;
        rd_half = 16'h0000;
        case (offset)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        strobe    = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        case (size)
            MEM_SIZE_B: begin
                strobe    = 4'b0001 << offset;
                wdata_rep = {(DATA_WIDTH/8){wdata[7:0]}};
                rdata_ext = {{(DATA_WIDTH-8){sign_ext & rd_byte[7]}}, rd_byte};
            end
            MEM_SIZE_H: begin
                strobe    = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {(DATA_WIDTH/16){wdata[15:0]}};
                rdata_ext = {{(DATA_WIDTH-16){sign_ext & rd_half[15]}}, rd_half};
            end
            default: begin
                strobe    = '1;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_initiator.sv
// Data-RAM initiator: one load/store at a time, one-cycle RAM access,
// registered response with aligned/extended load data or an alignment error.
module mem_access_initiator
    import mem_access_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS,
    parameter int DATA_WIDTH = DATA_BUS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [MEM_SIZE_BUS-1:0]  req_size,
    input  logic                     req_signed,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_addr_err,
    output logic                     ram_en,
    output logic [DATA_WIDTH/8-1:0]  ram_write_en,
    output logic [ADDR_WIDTH-1:0]    ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_write_data,
    input  logic [DATA_WIDTH-1:0]    ram_read_data,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic                      write_q, write_d;
    logic [MEM_SIZE_BUS-1:0]   size_q, size_d;
    logic                      signed_q, signed_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     resp_rdata_q, resp_rdata_d;
    logic                      resp_addr_err_q, resp_addr_err_d;

    logic                      handshake;
    logic                      req_misaligned;
    logic                      access_live;
    logic [DATA_WIDTH/8-1:0]   lane_strobe;
    logic [DATA_WIDTH-1:0]     lane_wdata;
    logic [DATA_WIDTH-1:0]     load_data;

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .chk_size   (req_size),
        .chk_offset (req_addr[1:0]),
        .misaligned (req_misaligned),
        .size       (size_q),
        .sign_ext   (signed_q),
        .offset     (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (ram_read_data),
        .strobe     (lane_strobe),
        .wdata_rep  (lane_wdata),
        .rdata_ext  (load_data)
    );

    assign req_ready = (state_q != ST_ACCESS);
    assign handshake = req_valid && req_ready;

    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        size_d          = size_q;
        signed_d        = signed_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        resp_rdata_d    = resp_rdata_q;
        resp_addr_err_d = resp_addr_err_q;
        case (state_q)
            ST_ACCESS: begin
                state_d         = ST_RESP;
                resp_rdata_d    = write_q ? '0 : load_data;
                resp_addr_err_d = 1'b0;
            end
            default: begin
                if (handshake) begin
                    write_d      = req_write;
                    size_d       = req_size;
                    signed_d     = req_signed;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    resp_rdata_d = '0;
                    // A misaligned request answers immediately and never touches the RAM.
                    resp_addr_err_d = req_misaligned;
                    state_d         = req_misaligned ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            write_q         <= 1'b0;
            size_q          <= MEM_SIZE_B;
            signed_q        <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            resp_rdata_q    <= '0;
            resp_addr_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            write_q         <= write_d;
            size_q          <= size_d;
            signed_q        <= signed_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_addr_err_q <= resp_addr_err_d;
        end
    end

    // Gating with rst_n keeps a reset during ACCESS from committing a write on that edge.
    assign access_live    = rst_n && (state_q == ST_ACCESS);
    assign ram_en         = access_live;
    assign ram_addr       = access_live ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign ram_write_en   = (access_live && write_q) ? lane_strobe : '0;
    assign ram_write_data = (access_live && write_q) ? lane_wdata : '0;

    assign resp_valid    = (state_q == ST_RESP);
    assign resp_rdata    = resp_rdata_q;
    assign resp_addr_err = resp_addr_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Bench for mem_access_initiator: a word RAM model on the bus, and a byte-array
// reference memory that predicts strobes, lane data, load results and errors.
module tb_mem_access_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_addr_err;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram [0:63];
    logic [31:0] seed [0:63];
    logic        ram_fill;
    logic [7:0]  ref_mem [0:255];

    always #5 clk = ~clk;

    mem_access_initiator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_addr_err  (resp_addr_err),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .dbg_state      (dbg_state)
    );

    // Single-cycle-read, posedge-write data RAM
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 64; i++) ram[i] <= seed[i];
        end else begin
            for (int k = 0; k < 4; k++)
                if (ram_write_en[k]) ram[ram_addr[7:2]][8*k +: 8] <= ram_write_data[8*k +: 8];
        end
    end
    assign ram_read_data = ram[ram_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) % 256];
        if (sg && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] ref_strobe(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s;
        s = 4'b0000;
        for (int i = 0; i < nbytes(sz); i++) s[(a % 4) + i] = 1'b1;
        return s;
    endfunction

    // Lane k carries store byte (k mod access-size)
    function automatic logic [31:0] ref_lanes(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) d[8*k +: 8] = wd[8*(k % nbytes(sz)) +: 8];
        return d;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[(a + i) % 256] = wd[8*i +: 8];
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic scramble_inputs(input logic keep_valid);
        req_valid  = keep_valid;
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom_range(0, 255);
        req_wdata  = $urandom;
    endtask

    // One complete request; called and returns just after a negedge.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int gap);
        logic        mis;
        logic [31:0] exp_rd;
        int          cyc;
        int          en_cnt;
        logic        got;
        repeat (gap) @(negedge clk);
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        drive(w, sz, sg, a, wd);
        @(posedge clk);
        mis    = ref_mis(sz, a);
        exp_rd = (w || mis) ? 32'h0 : ref_load(sz, sg, a);
        if (w && !mis) ref_store(sz, a, wd);
        cyc    = 0;
        en_cnt = 0;
        got    = 1'b0;
        while (!got && cyc < 6) begin
            @(negedge clk);
            scramble_inputs(1'b0);
            cyc++;
            if (ram_en) begin
                en_cnt++;
                check("access_ready", {31'b0, req_ready}, 32'd0);
                check("ram_addr", ram_addr, {a[31:2], 2'b00});
                check("ram_strobe", {28'b0, ram_write_en}, w ? {28'b0, ref_strobe(sz, a)} : 32'h0);
                check("ram_wdata", ram_write_data, w ? ref_lanes(sz, wd) : 32'h0);
            end
            got = resp_valid;
        end
        check("resp_seen", {31'b0, got}, 32'd1);
        check("resp_latency", cyc, mis ? 32'd1 : 32'd2);
        check("ram_en_count", en_cnt, mis ? 32'd0 : 32'd1);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", {31'b0, resp_addr_err}, {31'b0, mis});
        @(negedge clk);
        check("resp_pulse", {31'b0, resp_valid}, 32'd0);
        check("rdata_hold", resp_rdata, exp_rd);
        check("err_hold", {31'b0, resp_addr_err}, {31'b0, mis});
    endtask

    logic        p_w  [4];
    logic [1:0]  p_sz [4];
    logic        p_sg [4];
    logic [31:0] p_a  [4];
    logic [31:0] p_wd [4];
    logic [31:0] exp_q [$];

    initial begin
        logic [31:0] v, pre;
        logic [1:0]  sz;
        logic        w, sg;
        logic [31:0] a;

        for (int i = 0; i < 64; i++) begin
            seed[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = seed[i][8*b +: 8];
        end
        ram_fill = 1'b1;
        rst_n    = 1'b0;
        scramble_inputs(1'b0);
        repeat (3) @(negedge clk);
        ram_fill = 1'b0;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_addr_err}, 32'd0);
        check("rst_ram_en", {31'b0, ram_en}, 32'd0);
        check("rst_ram_we", {28'b0, ram_write_en}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_write_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Directed plan
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        check("lw_0x10", resp_rdata, 32'h12345678);
        run_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 0);
        run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
        check("lb_0x13", resp_rdata, 32'hFFFFFF80);
        run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1);
        check("lbu_0x13", resp_rdata, 32'h00000080);
        run_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 0);
        run_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0);
        check("lh_0x22", resp_rdata, 32'hFFFFBEEF);
        run_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
        check("lhu_0x22", resp_rdata, 32'h0000BEEF);
        run_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 0);
        check("low_half_kept", resp_rdata, {16'h0, seed[8][15:0]});
        run_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0);
        run_req(1'b1, 2'd1, 1'b0, 32'h21, 32'hCAFE, 0);

        // Back-to-back with req_valid held high
        for (int i = 0; i < 4; i++) begin
            p_w[i]  = (i % 2 == 0);
            p_sz[i] = 2'($urandom_range(0, 2));
            p_sg[i] = 1'($urandom_range(0, 1));
            p_a[i]  = 32'h40 + (i / 2) * 8 + (p_sz[i] == 2'd0 ? 32'd3 : p_sz[i] == 2'd1 ? 32'd2 : 32'd0);
            p_wd[i] = $urandom;
        end
        p_sz[1] = p_sz[0];
        p_a[1]  = p_a[0];
        p_sz[3] = p_sz[2];
        p_a[3]  = p_a[2];
        drive(p_w[0], p_sz[0], p_sg[0], p_a[0], p_wd[0]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            exp_q.push_back(p_w[i] ? 32'h0 : ref_load(p_sz[i], p_sg[i], p_a[i]));
            if (p_w[i]) ref_store(p_sz[i], p_a[i], p_wd[i]);
            @(negedge clk);
            check("b2b_ready_low", {31'b0, req_ready}, 32'd0);
            check("b2b_ram_en", {31'b0, ram_en}, 32'd1);
            check("b2b_strobe", {28'b0, ram_write_en}, p_w[i] ? {28'b0, ref_strobe(p_sz[i], p_a[i])} : 32'h0);
            scramble_inputs(1'b1);
            @(posedge clk);
            @(negedge clk);
            check("b2b_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("b2b_ready_high", {31'b0, req_ready}, 32'd1);
            check("b2b_rdata", resp_rdata, exp_q.pop_front());
            check("b2b_err", {31'b0, resp_addr_err}, 32'd0);
            if (i < 3) drive(p_w[i+1], p_sz[i+1], p_sg[i+1], p_a[i+1], p_wd[i+1]);
            else req_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_done", {31'b0, resp_valid}, 32'd0);

        // Reset during a store's ACCESS cycle
        pre = ref_load(2'd2, 1'b0, 32'h50);
        drive(1'b1, 2'd2, 1'b0, 32'h50, ~pre);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_ram_en", {31'b0, ram_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_gate_en", {31'b0, ram_en}, 32'd0);
        check("rst_gate_we", {28'b0, ram_write_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_acc_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_acc_rdata", resp_rdata, 32'd0);
        check("rst_acc_err", {31'b0, resp_addr_err}, 32'd0);
        check("rst_acc_ram_addr", ram_addr, 32'd0);
        check("rst_acc_ram_wdata", ram_write_data, 32'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("rst_acc_no_resp", {31'b0, resp_valid}, 32'd0);
        run_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 0);
        check("rst_acc_word_kept", resp_rdata, pre);

        // Reset during RESP
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resp_before_rst", {31'b0, resp_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resp_after_rst", {31'b0, resp_valid}, 32'd0);
        check("rdata_after_rst", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
            v  = $urandom;
            run_req(w, sz, sg, a, v, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
